// File: rtl/blind_pkg.sv
// blind_pkg: shared state encoding, direction constants and default timing for the blind motor driver
package blind_pkg;
  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_e;
  localparam logic DIR_OPEN = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_DEAD_CYC = 4;
  localparam int DEF_RAMP_STEP = 256;
endpackage

// File: rtl/blind_pwm_ramp.sv
// blind_pwm_ramp: free-running pwm counter with soft-start duty ramp clamped to duty_max
module blind_pwm_ramp
  import blind_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic                pwm_on
);
  localparam int RW = RAMP_STEP > 1 ? $clog2(RAMP_STEP) : 1;
  logic [PWM_BITS-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic step;
  // next counter, ramp and duty; a lowered ceiling pulls duty down immediately
  always_comb begin
    step = ramp_q == RW'(RAMP_STEP - 1);
    cnt_d = restart ? '0 : cnt_q + 1'b1;
    ramp_d = (restart || step) ? '0 : ramp_q + 1'b1;
    duty_d = restart ? '0 :
             duty_q > duty_max ? duty_max :
             (step && duty_q < duty_max) ? duty_q + 1'b1 : duty_q;
    pwm_on = cnt_q < duty_q;
  end
  // ramp state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ramp_q <= '0;
      duty_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ramp_q <= ramp_d;
      duty_q <= duty_d;
    end
  end
endmodule

// File: rtl/blind_motor_driver.sv
// blind_motor_driver: H-bridge driver with dead-time, soft-start, end-stop and timeout protection
module blind_motor_driver
  import blind_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int DEAD_CYC = DEF_DEAD_CYC,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int TIMEOUT_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_open,
  input  logic                cmd_close,
  input  logic                cmd_stop,
  input  logic                lim_open,
  input  logic                lim_closed,
  input  logic [PWM_BITS-1:0] duty_max,
  input  logic                fault_clr,
  output logic                hb_a,
  output logic                hb_b,
  output logic                busy,
  output logic                at_open,
  output logic                at_closed,
  output logic                fault
);
  localparam int DW = $clog2(DEAD_CYC + 1);
  state_e state_q, state_d;
  logic dir_q, dir_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
  logic pwm_on, stop, go_open, go_close, lim_dir, reverse;
  logic hb_a_q, hb_b_q, busy_q, at_open_q, at_closed_q, fault_q;

  blind_pwm_ramp #(.PWM_BITS(PWM_BITS), .RAMP_STEP(RAMP_STEP)) u_ramp (
    .clk(clk),
    .rst(rst),
    .restart(state_q != DRIVE),
    .duty_max(duty_max),
    .pwm_on(pwm_on)
  );

  // command decode, next-state logic, dead-time and travel counters
  always_comb begin
    stop = cmd_stop | (cmd_open & cmd_close);
    go_open = cmd_open & ~stop;
    go_close = cmd_close & ~stop;
    lim_dir = dir_q ? lim_open : lim_closed;
    reverse = dir_q ? go_close & ~lim_closed : go_open & ~lim_open;
    tmr_d = state_q == DRIVE ? tmr_q + 1'b1 : '0;
    state_d = state_q;
    dir_d = dir_q;
    if (lim_open && lim_closed && state_q != FAULT) state_d = FAULT;
    else case (state_q)
      IDLE: begin
        if (go_open && !lim_open) begin
          state_d = DEAD;
          dir_d = DIR_OPEN;
        end else if (go_close && !lim_closed) begin
          state_d = DEAD;
          dir_d = DIR_CLOSE;
        end
      end
      DEAD: state_d = (stop || lim_dir) ? IDLE : dcnt_q == DW'(DEAD_CYC - 1) ? DRIVE : DEAD;
      DRIVE: begin
        if (lim_dir || stop) state_d = IDLE;
        else if (reverse) begin
          state_d = DEAD;
          dir_d = ~dir_q;
        end else if (&tmr_d) state_d = FAULT;
      end
      FAULT: state_d = (fault_clr && !(lim_open && lim_closed)) ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
    dcnt_d = (state_q == DEAD && state_d == DEAD) ? dcnt_q + 1'b1 : '0;
  end

  // state and registered outputs, decoded from the next state so exits drop the legs on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q <= DIR_CLOSE;
      dcnt_q <= '0;
      tmr_q <= '0;
      hb_a_q <= 1'b0;
      hb_b_q <= 1'b0;
      busy_q <= 1'b0;
      at_open_q <= 1'b0;
      at_closed_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      dcnt_q <= dcnt_d;
      tmr_q <= tmr_d;
      hb_a_q <= state_d == DRIVE && dir_d && pwm_on;
      hb_b_q <= state_d == DRIVE && !dir_d && pwm_on;
      busy_q <= state_d == DEAD || state_d == DRIVE;
      at_open_q <= lim_open;
      at_closed_q <= lim_closed;
      fault_q <= state_d == FAULT;
    end
  end

  assign hb_a = hb_a_q;
  assign hb_b = hb_b_q;
  assign busy = busy_q;
  assign at_open = at_open_q;
  assign at_closed = at_closed_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_blind_motor_driver.sv
// tb_blind_motor_driver: directed checks of ramp, limits, reversal, timeout and sensor fault
module tb_blind_motor_driver;
  logic clk = 0, rst = 1;
  logic cmd_open = 0, cmd_close = 0, cmd_stop = 0, lim_open = 0, lim_closed = 0, fault_clr = 0;
  logic [7:0] duty_max = 8'h40;
  logic a0, b0, busy0, ao0, ac0, f0, a1, b1, busy1, ao1, ac1, f1;
  int checks = 0, errors = 0, overlap = 0;

  always #5 clk = ~clk;

  blind_motor_driver u0 (
    .clk(clk), .rst(rst), .cmd_open(cmd_open), .cmd_close(cmd_close), .cmd_stop(cmd_stop),
    .lim_open(lim_open), .lim_closed(lim_closed), .duty_max(duty_max), .fault_clr(fault_clr),
    .hb_a(a0), .hb_b(b0), .busy(busy0), .at_open(ao0), .at_closed(ac0), .fault(f0)
  );

  blind_motor_driver #(.TIMEOUT_W(6)) u1 (
    .clk(clk), .rst(rst), .cmd_open(cmd_open), .cmd_close(cmd_close), .cmd_stop(cmd_stop),
    .lim_open(lim_open), .lim_closed(lim_closed), .duty_max(duty_max), .fault_clr(fault_clr),
    .hb_a(a1), .hb_b(b1), .busy(busy1), .at_open(ao1), .at_closed(ac1), .fault(f1)
  );

  always @(negedge clk) if (!rst && ((a0 && b0) || (a1 && b1))) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first, cnt;
    tick(3);
    check("reset_outputs", {a0, b0, busy0, ao0, ac0, f0, f1, busy1}, 0);
    rst = 0;
    tick();
    cmd_open = 1;
    tick();
    cmd_open = 0;
    check("open_busy", busy0, 1);
    check("open_dead_a", a0, 0);
    first = -1;
    for (int i = 1; i <= 400 && first < 0; i++) begin
      tick();
      if (a0) first = i;
    end
    check("open_first_pwm", first, 261);
    cnt = 0;
    repeat (64 * 256) begin
      tick();
      cnt += int'(b0);
    end
    check("open_b_idle", cnt, 0);
    cnt = 0;
    repeat (256) begin
      tick();
      cnt += int'(a0);
    end
    check("duty_saturated", cnt, 64);
    duty_max = 8'h10;
    tick(2);
    cnt = 0;
    repeat (256) begin
      tick();
      cnt += int'(a0);
    end
    check("duty_clamped", cnt, 16);
    duty_max = 8'h40;
    lim_open = 1;
    tick();
    check("lim_a_off", a0, 0);
    check("lim_busy", busy0, 0);
    check("lim_at_open", ao0, 1);
    cmd_open = 1;
    tick();
    cmd_open = 0;
    tick(5);
    check("open_at_lim_ignored", {busy0, a0}, 0);
    lim_open = 0;
    cmd_open = 1;
    tick();
    cmd_open = 0;
    tick(1000);
    cmd_close = 1;
    tick();
    cmd_close = 0;
    check("rev_a_off", a0, 0);
    check("rev_busy", busy0, 1);
    first = -1;
    cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      cnt += int'(a0);
      if (b0 && first < 0) first = i;
    end
    check("rev_first_b", first, 261);
    check("rev_no_a", cnt, 0);
    cmd_open = 1;
    cmd_close = 1;
    tick();
    cmd_open = 0;
    cmd_close = 0;
    check("both_cmd_stop", {a0, b0, busy0}, 0);
    rst = 1;
    tick();
    rst = 0;
    cmd_close = 1;
    tick();
    cmd_close = 0;
    tick(66);
    check("timeout_before", {f1, busy1}, 2'b01);
    tick();
    check("timeout_fault", {f1, a1, b1, busy1}, 4'b1000);
    fault_clr = 1;
    tick();
    fault_clr = 0;
    check("timeout_clr", {f1, busy1}, 0);
    lim_open = 1;
    lim_closed = 1;
    tick();
    check("sensor_fault", {f0, a0, b0, busy0, ao0, ac0}, 6'b100011);
    fault_clr = 1;
    tick();
    fault_clr = 0;
    check("sensor_clr_blocked", f0, 1);
    lim_closed = 0;
    tick();
    fault_clr = 1;
    tick();
    fault_clr = 0;
    check("sensor_clr", {f0, busy0}, 0);
    lim_open = 0;
    cmd_open = 1;
    tick();
    cmd_open = 0;
    first = -1;
    for (int i = 1; i <= 600 && first < 0; i++) begin
      tick();
      if (a0) first = i;
    end
    check("rst_drive_pwm", first, 261);
    rst = 1;
    tick();
    check("rst_drive_outputs", {a0, b0, busy0, f0}, 0);
    rst = 0;
    tick(2);
    check("no_leg_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
